controlador_irrigacao: RTL and testbench

CONTROLADOR_IRRIGACAO -- requirements
Module: controlador_irrigacao

---
 rtl/controlador_irrigacao_if.sv | 39 +++
 rtl/controlador_irrigacao.sv | 139 +++++++++++++
 tb/tb_controlador_irrigacao.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/controlador_irrigacao_if.sv
// -----------------------------------------------------------------------------
// controlador_irrigacao_if
// Groups the command, sensor and drive signals of the irrigation controller.
//   tick     : one-clock time-base pulse (timers advance only on it)
//   iniciar  : start request (level)
//   parar    : abort request (level, dominates iniciar)
//   seco     : per-zone soil sensor, 1 = dry
//   valvula  : valve drives, one-hot or all-zero
//   bomba    : pump drive
//   zona     : zone currently handled
//   tempo    : timer inside WATER/PAUSE, 0 elsewhere
//   ocupado  : controller busy (not IDLE)
//   fim      : one-clock cycle-completion pulse
// master drives the commands/sensors, slave is the controller.
// -----------------------------------------------------------------------------
interface controlador_irrigacao_if #(
    parameter int ZONAS = 4
);
    logic             tick;
    logic             iniciar;
    logic             parar;
    logic [ZONAS-1:0] seco;
    logic [ZONAS-1:0] valvula;
    logic             bomba;
    logic [1:0]       zona;
    logic [3:0]       tempo;
    logic             ocupado;
    logic             fim;

    modport master (
        output tick, iniciar, parar, seco,
        input  valvula, bomba, zona, tempo, ocupado, fim
    );

    modport slave (
        input  tick, iniciar, parar, seco,
        output valvula, bomba, zona, tempo, ocupado, fim
    );
endinterface

// File: rtl/controlador_irrigacao.sv
// -----------------------------------------------------------------------------
// controlador_irrigacao
// Sequential multi-zone irrigation controller. A cycle visits zones 0..ZONAS-1;
// a dry zone is watered for T_REGA ticks (or until it reports wet) and is
// followed by a T_PAUSA-tick settling pause; wet zones are skipped in one clock.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : controlador_irrigacao_if.slave (tick, iniciar, parar, seco in;
//           valvula, bomba, zona, tempo, ocupado, fim out)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module controlador_irrigacao #(
    parameter int ZONAS   = 4,
    parameter int T_REGA  = 9,
    parameter int T_PAUSA = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    controlador_irrigacao_if.slave bus
);

    typedef enum logic [2:0] {IDLE, CHECK, WATER, PAUSE, FIM} estado_t;

    localparam logic [1:0] ULTIMA    = 2'(ZONAS - 1);
    localparam logic [3:0] FIM_REGA  = 4'(T_REGA - 1);
    localparam logic [3:0] FIM_PAUSA = 4'(T_PAUSA - 1);

    estado_t          estado;
    logic [1:0]       zona_r;
    logic [3:0]       tempo_r;
    logic [ZONAS-1:0] valvula_r;
    logic             bomba_r;
    logic             ocupado_r;
    logic             fim_r;
    logic             seco_atual;

    function automatic logic [ZONAS-1:0] decodificar(input logic [1:0] z);
        return {{(ZONAS-1){1'b0}}, 1'b1} << z;
    endfunction

    assign seco_atual  = bus.seco[zona_r];

    assign bus.valvula = valvula_r;
    assign bus.bomba   = bomba_r;
    assign bus.zona    = zona_r;
    assign bus.tempo   = tempo_r;
    assign bus.ocupado = ocupado_r;
    assign bus.fim     = fim_r;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= IDLE;
            zona_r    <= '0;
            tempo_r   <= '0;
            valvula_r <= '0;
            bomba_r   <= 1'b0;
            ocupado_r <= 1'b0;
            fim_r     <= 1'b0;
        end else begin
            fim_r <= 1'b0;
            if (estado != IDLE && bus.parar) begin
                // Abort: everything off, no completion pulse.
                estado    <= IDLE;
                zona_r    <= '0;
                tempo_r   <= '0;
                valvula_r <= '0;
                bomba_r   <= 1'b0;
                ocupado_r <= 1'b0;
            end else begin
                case (estado)
                    IDLE: begin
                        if (bus.iniciar && !bus.parar) begin
                            estado    <= CHECK;
                            zona_r    <= '0;
                            tempo_r   <= '0;
                            ocupado_r <= 1'b1;
                        end
                    end
                    CHECK: begin
                        if (seco_atual) begin
                            estado    <= WATER;
                            tempo_r   <= '0;
                            valvula_r <= decodificar(zona_r);
                            bomba_r   <= 1'b1;
                        end else if (zona_r == ULTIMA) begin
                            estado <= FIM;
                            fim_r  <= 1'b1;
                        end else begin
                            zona_r <= zona_r + 2'd1;
                        end
                    end
                    WATER: begin
                        // A zone turning wet ends watering even without a tick,
                        // and a coincident tick does not add a second step.
                        if (!seco_atual || (bus.tick && tempo_r == FIM_REGA)) begin
                            estado    <= PAUSE;
                            tempo_r   <= '0;
                            valvula_r <= '0;
                            bomba_r   <= 1'b0;
                        end else if (bus.tick) begin
                            tempo_r <= tempo_r + 4'd1;
                        end
                    end
                    PAUSE: begin
                        if (bus.tick) begin
                            if (tempo_r == FIM_PAUSA) begin
                                tempo_r <= '0;
                                if (zona_r == ULTIMA) begin
                                    estado <= FIM;
                                    fim_r  <= 1'b1;
                                end else begin
                                    estado <= CHECK;
                                    zona_r <= zona_r + 2'd1;
                                end
                            end else begin
                                tempo_r <= tempo_r + 4'd1;
                            end
                        end
                    end
                    FIM: begin
                        estado    <= IDLE;
                        zona_r    <= '0;
                        ocupado_r <= 1'b0;
                    end
                    default: begin
                        estado    <= IDLE;
                        zona_r    <= '0;
                        tempo_r   <= '0;
                        valvula_r <= '0;
                        bomba_r   <= 1'b0;
                        ocupado_r <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_controlador_irrigacao.sv
// -----------------------------------------------------------------------------
// tb_controlador_irrigacao
// Directed scenarios followed by randomized traffic for controlador_irrigacao,
// compared every clock against a behavioural model of the irrigation rules.
// -----------------------------------------------------------------------------
module tb_controlador_irrigacao;

    localparam int Z  = 4;
    localparam int TR = 9;
    localparam int TP = 3;

    localparam int M_IDLE  = 0;
    localparam int M_CHECK = 1;
    localparam int M_WATER = 2;
    localparam int M_PAUSE = 3;
    localparam int M_FIM   = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    controlador_irrigacao_if #(.ZONAS(Z)) bus ();

    controlador_irrigacao #(
        .ZONAS  (Z),
        .T_REGA (TR),
        .T_PAUSA(TP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: activity, zone and elapsed ticks of the current phase.
    int m_mode;
    int m_zone;
    int m_time;

    function automatic void model_reset();
        m_mode = M_IDLE;
        m_zone = 0;
        m_time = 0;
    endfunction

    function automatic void model_step();
        if (m_mode == M_IDLE) begin
            if (bus.iniciar && !bus.parar) begin
                m_mode = M_CHECK;
                m_zone = 0;
                m_time = 0;
            end
        end else if (bus.parar) begin
            model_reset();
        end else begin
            case (m_mode)
                M_CHECK: begin
                    if (bus.seco[m_zone]) begin
                        m_mode = M_WATER;
                        m_time = 0;
                    end else if (m_zone == Z - 1) m_mode = M_FIM;
                    else m_zone = m_zone + 1;
                end
                M_WATER: begin
                    if (!bus.seco[m_zone] || (bus.tick && m_time + 1 == TR)) begin
                        m_mode = M_PAUSE;
                        m_time = 0;
                    end else if (bus.tick) m_time = m_time + 1;
                end
                M_PAUSE: begin
                    if (bus.tick) begin
                        if (m_time + 1 == TP) begin
                            m_time = 0;
                            if (m_zone == Z - 1) m_mode = M_FIM;
                            else begin
                                m_zone = m_zone + 1;
                                m_mode = M_CHECK;
                            end
                        end else m_time = m_time + 1;
                    end
                end
                default: model_reset();
            endcase
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string ph);
        logic        agua;
        logic [31:0] v_exp;
        agua  = (m_mode == M_WATER);
        v_exp = agua ? (32'd1 << m_zone) : 32'd0;
        check({ph, ".valvula"}, 32'(bus.valvula), v_exp);
        check({ph, ".bomba"},   32'(bus.bomba),   32'(agua));
        check({ph, ".zona"},    32'(bus.zona),    32'(m_zone));
        check({ph, ".tempo"},   32'(bus.tempo),
              (agua || m_mode == M_PAUSE) ? 32'(m_time) : 32'd0);
        check({ph, ".ocupado"}, 32'(bus.ocupado), 32'(m_mode != M_IDLE));
        check({ph, ".fim"},     32'(bus.fim),     32'(m_mode == M_FIM));
    endtask

    task automatic step(input string ph);
        @(posedge clock);
        if (reset) model_step();
        else model_reset();
        @(negedge clock);
        compare_all(ph);
    endtask

    task automatic pulso_reset(input string ph);
        #2 reset = 1'b0;
        #1 model_reset();
        compare_all(ph);
        @(negedge clock);
        reset = 1'b1;
    endtask

    int          ticks;
    int          fim_tick;
    int          fims;
    int          ruins;
    logic        viu1;
    logic        viu4;

    initial begin
        bus.tick    = 1'b0;
        bus.iniciar = 1'b0;
        bus.parar   = 1'b0;
        bus.seco    = '0;
        model_reset();

        // Reset state, then idle until iniciar
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        compare_all("reset");
        reset = 1'b1;
        repeat (3) step("pos_reset");

        // All zones dry: 4 x (9 + 3) ticks, fim after the 48th tick
        bus.seco    = 4'b1111;
        bus.iniciar = 1'b1;
        step("cheio.ini");
        bus.iniciar = 1'b0;
        ticks = 0; fim_tick = -1; fims = 0;
        for (int c = 0; c < 160; c++) begin
            bus.tick = (c % 3 == 2);
            step("cheio");
            if (bus.tick) ticks++;
            if (bus.fim === 1'b1) begin
                fims++;
                fim_tick = ticks;
            end
        end
        bus.tick = 1'b0;
        check("cheio.n_fim", 32'(fims), 32'd1);
        check("cheio.fim_tick", 32'(fim_tick), 32'(Z * (TR + TP)));
        check("cheio.ocupado_final", 32'(bus.ocupado), 32'd0);

        // No dry zone: four CHECK clocks then fim
        bus.seco    = 4'b0000;
        bus.iniciar = 1'b1;
        step("seco0.ini");
        bus.iniciar = 1'b0;
        check("seco0.z0", 32'(bus.zona), 32'd0);
        for (int k = 1; k < 4; k++) begin
            step("seco0");
            check("seco0.zk", 32'(bus.zona), 32'(k));
            check("seco0.fim_baixo", 32'(bus.fim), 32'd0);
        end
        step("seco0.fim");
        check("seco0.fim_alto", 32'(bus.fim), 32'd1);
        step("seco0.depois");
        check("seco0.ocioso", 32'(bus.ocupado), 32'd0);

        // Zones 0 and 2 dry only
        bus.seco    = 4'b0101;
        bus.iniciar = 1'b1;
        step("alt.ini");
        bus.iniciar = 1'b0;
        ruins = 0; viu1 = 1'b0; viu4 = 1'b0;
        for (int c = 0; c < 120; c++) begin
            bus.tick = (c % 3 == 2);
            step("alt");
            if (bus.valvula == 4'b0001) viu1 = 1'b1;
            else if (bus.valvula == 4'b0100) viu4 = 1'b1;
            else if (bus.valvula != 4'b0000) ruins++;
        end
        bus.tick = 1'b0;
        check("alt.outras_valvulas", 32'(ruins), 32'd0);
        check("alt.viu_0001", 32'(viu1), 32'd1);
        check("alt.viu_0100", 32'(viu4), 32'd1);

        // Zone 0 turns wet at tempo 4 with a coincident tick
        bus.seco    = 4'b1111;
        bus.iniciar = 1'b1;
        step("molha.ini");
        bus.iniciar = 1'b0;
        step("molha.agua");
        bus.tick = 1'b1;
        repeat (4) step("molha.ticks");
        check("molha.tempo4", 32'(bus.tempo), 32'd4);
        bus.seco = 4'b1110;
        step("molha.cai");
        check("molha.tempo0", 32'(bus.tempo), 32'd0);
        check("molha.bomba0", 32'(bus.bomba), 32'd0);
        check("molha.valv0", 32'(bus.valvula), 32'd0);
        bus.seco = 4'b1111;
        repeat (3) step("molha.pausa");
        bus.tick = 1'b0;
        check("molha.check_z1", 32'(bus.zona), 32'd1);
        step("molha.z1");
        check("molha.valv_z1", 32'(bus.valvula), 32'b0010);

        // parar at tempo 6 with iniciar held
        bus.tick = 1'b1;
        repeat (6) step("parar.ticks");
        bus.tick = 1'b0;
        check("parar.tempo6", 32'(bus.tempo), 32'd6);
        bus.iniciar = 1'b1;
        bus.parar   = 1'b1;
        step("parar.aborta");
        check("parar.ocupado", 32'(bus.ocupado), 32'd0);
        check("parar.valvula", 32'(bus.valvula), 32'd0);
        check("parar.fim", 32'(bus.fim), 32'd0);
        repeat (3) step("parar.segura");
        check("parar.segue_ocioso", 32'(bus.ocupado), 32'd0);
        bus.parar = 1'b0;
        step("parar.solta");
        check("parar.reinicia", 32'(bus.ocupado), 32'd1);
        bus.iniciar = 1'b0;

        // Asynchronous reset while watering zone 2
        bus.seco = 4'b0100;
        repeat (3) step("rst.chega_z2");
        check("rst.valv_z2", 32'(bus.valvula), 32'b0100);
        bus.tick = 1'b1;
        repeat (2) step("rst.ticks");
        bus.tick = 1'b0;
        pulso_reset("rst.meio_rega");
        check("rst.valvula0", 32'(bus.valvula), 32'd0);
        check("rst.ocupado0", 32'(bus.ocupado), 32'd0);
        repeat (4) step("rst.ocioso");
        check("rst.fica_ocioso", 32'(bus.ocupado), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            bus.tick    = ($urandom_range(0, 3) == 0);
            bus.iniciar = ($urandom_range(0, 7) == 0);
            bus.parar   = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 15) == 0) bus.seco = 4'($urandom);
            step("aleatorio");
            if ($urandom_range(0, 499) == 0) pulso_reset("aleatorio.reset");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
